wash_sequencer: RTL and testbench

Parametrised washing-machine controller and successor to the fixed-timing FSM controller. It sequences fill, wash, drain, a configurable number of rinse/drain passes and spin using one shared phase down-counter. Compared with the previous controller it adds:
- the program latched at start,
- pause/resume,
- abort with forced drain,
- door-open fault detection,
- a live remaining-time output.

It sits between the front-panel inputs and the valve/motor drivers.

---
 rtl/wash_pkg.sv | 51 +++++
 rtl/phase_timer.sv | 37 +++
 rtl/wash_sequencer.sv | 217 +++++++++++++++++++++
 tb/tb_wash_sequencer.sv | 356 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wash_pkg.sv
// Shared types and helpers for the wash sequencer.
// Holds the state enumeration, program and motor codes, and the remaining-phase total.
package wash_pkg;

   typedef enum logic [3:0] {
      StIdle,
      StFill,
      StWaitSoap,
      StWash,
      StDrainW,
      StRinse,
      StDrainR,
      StSpin,
      StAbortDrain,
      StDone
   } state_e;

   localparam logic [2:0] ProgCold     = 3'b000;
   localparam logic [2:0] ProgHot      = 3'b001;
   localparam logic [2:0] ProgRinseDry = 3'b010;
   localparam logic [2:0] ProgOnlyDry  = 3'b011;
   localparam logic [2:0] ProgWarm     = 3'b100;

   localparam logic [1:0] MotorOff     = 2'b00;
   localparam logic [1:0] MotorAgitate = 2'b01;
   localparam logic [1:0] MotorSpin    = 2'b10;

   function automatic logic prog_valid(input logic [2:0] p);
      return p <= ProgWarm;
   endfunction

   // Cycles of all phases that follow the current one; ridx is the current rinse pass.
   function automatic int unsigned phases_after(input state_e st, input int unsigned ridx,
                                                input int unsigned n_rinse,
                                                input int unsigned wash, input int unsigned drain,
                                                input int unsigned rinse, input int unsigned spin);
      int unsigned pass;
      int unsigned left;
      pass = rinse + drain;
      left = n_rinse - 1 - ridx;
      case (st)
         StFill, StWaitSoap: return wash + drain + n_rinse * pass + spin;
         StWash:             return drain + n_rinse * pass + spin;
         StDrainW:           return n_rinse * pass + spin;
         StRinse:            return drain + left * pass + spin;
         StDrainR:           return left * pass + spin;
         default:            return 0;
      endcase
   endfunction

endpackage

// File: rtl/phase_timer.sv
// Phase down-counter shared by every wash phase.
// load has priority over en; the count never wraps below zero.
module phase_timer #(
   parameter int unsigned TW = 8
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          load,
   input  logic [TW-1:0] load_val,
   input  logic          en,
   output logic [TW-1:0] cnt,
   output logic          zero
);

   logic [TW-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (en && (cnt_q != '0)) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign zero = (cnt_q == '0);

endmodule

// File: rtl/wash_sequencer.sv
// Washing-machine sequencer: fill, wash, drain, rinse passes and spin on one phase timer,
// with pause, abort, door fault and a live remaining-time output.
module wash_sequencer
   import wash_pkg::*;
#(
   parameter int unsigned TW        = 8,
   parameter int unsigned FILL_CYC  = 2,
   parameter int unsigned WASH_CYC  = 3,
   parameter int unsigned DRAIN_CYC = 2,
   parameter int unsigned RINSE_CYC = 3,
   parameter int unsigned SPIN_CYC  = 4,
   parameter int unsigned N_RINSE   = 2,
   parameter int unsigned REM_W     = TW + 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             power,
   input  logic             start,
   input  logic [2:0]       program_selection,
   input  logic             door_closed,
   input  logic             soap,
   input  logic             pause,
   input  logic             abort,
   output logic             valve_in_cold,
   output logic             valve_in_hot,
   output logic             valve_out,
   output logic [1:0]       motor,
   output logic             soap_in,
   output logic             soap_warning,
   output logic             lock_door,
   output logic             paused,
   output logic             program_done,
   output logic             fault,
   output logic [REM_W-1:0] rem_time
);

   state_e        state_q, state_d;
   logic [2:0]    prog_q, prog_d;
   logic [3:0]    rinse_q, rinse_d;
   logic          fault_q, fault_d;
   logic          paused_q, paused_d;
   logic          tmr_load, tmr_en, cnt_zero;
   logic [TW-1:0] tmr_val, cnt;

   phase_timer #(
      .TW(TW)
   ) u_timer (
      .clk     (clk),
      .rst     (rst),
      .load    (tmr_load),
      .load_val(tmr_val),
      .en      (tmr_en),
      .cnt     (cnt),
      .zero    (cnt_zero)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= StIdle;
         prog_q   <= ProgCold;
         rinse_q  <= '0;
         fault_q  <= 1'b0;
         paused_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         prog_q   <= prog_d;
         rinse_q  <= rinse_d;
         fault_q  <= fault_d;
         paused_q <= paused_d;
      end
   end

   always_comb begin
      state_d  = state_q;
      prog_d   = prog_q;
      rinse_d  = rinse_q;
      fault_d  = fault_q;
      paused_d = 1'b0;
      tmr_load = 1'b0;
      tmr_val  = '0;
      tmr_en   = 1'b0;
      unique case (state_q)
         StIdle: begin
            if (power && start && door_closed && prog_valid(program_selection)) begin
               prog_d   = program_selection;
               fault_d  = 1'b0;
               rinse_d  = '0;
               tmr_load = 1'b1;
               unique case (program_selection)
                  ProgRinseDry: begin
                     state_d = StRinse;
                     tmr_val = TW'(RINSE_CYC - 1);
                  end
                  ProgOnlyDry: begin
                     state_d = StSpin;
                     tmr_val = TW'(SPIN_CYC - 1);
                  end
                  default: begin
                     state_d = StFill;
                     tmr_val = TW'(FILL_CYC - 1);
                  end
               endcase
            end
         end
         // Abort drain ignores pause, abort and the door until it completes.
         StAbortDrain: begin
            tmr_en = !cnt_zero;
            if (cnt_zero) begin
               state_d = StIdle;
            end
         end
         StDone: state_d = StIdle;
         default: begin
            if (!door_closed || abort) begin
               fault_d  = fault_q | !door_closed;
               state_d  = StAbortDrain;
               tmr_load = 1'b1;
               tmr_val  = TW'(DRAIN_CYC - 1);
            end else if (pause) begin
               paused_d = 1'b1;
            end else if (state_q == StWaitSoap) begin
               if (soap) begin
                  state_d = StFill;
               end
            end else if ((state_q == StFill) && !soap) begin
               state_d = StWaitSoap;
            end else begin
               tmr_en = !cnt_zero;
               if (cnt_zero) begin
                  unique case (state_q)
                     StFill: begin
                        state_d  = StWash;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(WASH_CYC - 1);
                     end
                     StWash: begin
                        state_d  = StDrainW;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(DRAIN_CYC - 1);
                     end
                     StDrainW: begin
                        state_d  = StRinse;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(RINSE_CYC - 1);
                     end
                     StRinse: begin
                        state_d  = StDrainR;
                        tmr_load = 1'b1;
                        tmr_val  = TW'(DRAIN_CYC - 1);
                     end
                     StDrainR: begin
                        tmr_load = 1'b1;
                        if (rinse_q < 4'(N_RINSE - 1)) begin
                           rinse_d = rinse_q + 4'd1;
                           state_d = StRinse;
                           tmr_val = TW'(RINSE_CYC - 1);
                        end else begin
                           state_d = StSpin;
                           tmr_val = TW'(SPIN_CYC - 1);
                        end
                     end
                     StSpin: state_d = StDone;
                     default: ;
                  endcase
               end
            end
         end
      endcase
   end

   always_comb begin
      valve_in_cold = 1'b0;
      valve_in_hot  = 1'b0;
      valve_out     = 1'b0;
      motor         = MotorOff;
      soap_in       = 1'b0;
      soap_warning  = 1'b0;
      program_done  = 1'b0;
      lock_door     = (state_q != StIdle) && (state_q != StDone);
      unique case (state_q)
         StFill: begin
            soap_in       = 1'b1;
            valve_in_cold = (prog_q == ProgCold) || (prog_q == ProgWarm);
            valve_in_hot  = (prog_q == ProgHot) || (prog_q == ProgWarm);
         end
         StWash:                           motor = MotorAgitate;
         StDrainW, StDrainR, StAbortDrain: valve_out = 1'b1;
         StRinse:                          valve_in_cold = 1'b1;
         StSpin:                           motor = MotorSpin;
         StWaitSoap:                       soap_warning = 1'b1;
         StDone:                           program_done = 1'b1;
         default: ;
      endcase
      if (paused_q) begin
         valve_in_cold = 1'b0;
         valve_in_hot  = 1'b0;
         valve_out     = 1'b0;
         motor         = MotorOff;
         soap_in       = 1'b0;
      end
   end

   assign paused = paused_q;
   assign fault  = fault_q;

   always_comb begin
      rem_time = '0;
      if (state_q == StAbortDrain) begin
         rem_time = REM_W'(cnt) + REM_W'(1);
      end else if ((state_q != StIdle) && (state_q != StDone)) begin
         rem_time = REM_W'(cnt) + REM_W'(1)
                  + REM_W'(phases_after(state_q, 32'(rinse_q), N_RINSE, WASH_CYC, DRAIN_CYC,
                                        RINSE_CYC, SPIN_CYC));
      end
   end

endmodule

// File: tb/tb_wash_sequencer.sv
// Scoreboard bench for wash_sequencer: the driver queues per-cycle expected outputs,
// the monitor compares them on the falling edge.
module tb_wash_sequencer;

   localparam int unsigned REM_W = 12;

   // {cold, hot, vout, motor[1:0], soap_in, warn, lock, paused, done, fault}
   localparam logic [10:0] PatIdle     = 11'b00000000000;
   localparam logic [10:0] PatFillCold = 11'b10000101000;
   localparam logic [10:0] PatFillWarm = 11'b11000101000;
   localparam logic [10:0] PatWash     = 11'b00001001000;
   localparam logic [10:0] PatDrain    = 11'b00100001000;
   localparam logic [10:0] PatRinse    = 11'b10000001000;
   localparam logic [10:0] PatSpin     = 11'b00010001000;
   localparam logic [10:0] PatWaitSoap = 11'b00000011000;
   localparam logic [10:0] PatPaused   = 11'b00000001100;
   localparam logic [10:0] PatDone     = 11'b00000000010;
   localparam logic [10:0] PatFault    = 11'b00000000001;

   typedef struct {
      int          cyc;
      int          which;
      logic [10:0] bits;
      int          rem;
      string       name;
   } exp_t;

   logic clk, rst, power, start, door_closed, soap, pause, abort;
   logic [2:0] program_selection;

   logic valve_in_cold, valve_in_hot, valve_out, soap_in, soap_warning, lock_door, paused;
   logic program_done, fault;
   logic [1:0] motor;
   logic [REM_W-1:0] rem_time;

   logic d3_cold, d3_hot, d3_vout, d3_soap_in, d3_warn, d3_lock, d3_paused, d3_done, d3_fault;
   logic [1:0] d3_motor;
   logic [REM_W-1:0] d3_rem;

   logic [10:0] w0, w3;
   assign w0 = {valve_in_cold, valve_in_hot, valve_out, motor, soap_in, soap_warning, lock_door,
                paused, program_done, fault};
   assign w3 = {d3_cold, d3_hot, d3_vout, d3_motor, d3_soap_in, d3_warn, d3_lock, d3_paused,
                d3_done, d3_fault};

   wash_sequencer dut (
      .clk(clk), .rst(rst), .power(power), .start(start),
      .program_selection(program_selection), .door_closed(door_closed), .soap(soap),
      .pause(pause), .abort(abort), .valve_in_cold(valve_in_cold), .valve_in_hot(valve_in_hot),
      .valve_out(valve_out), .motor(motor), .soap_in(soap_in), .soap_warning(soap_warning),
      .lock_door(lock_door), .paused(paused), .program_done(program_done), .fault(fault),
      .rem_time(rem_time)
   );

   wash_sequencer #(.N_RINSE(3)) dut3 (
      .clk(clk), .rst(rst), .power(power), .start(start),
      .program_selection(program_selection), .door_closed(door_closed), .soap(soap),
      .pause(pause), .abort(abort), .valve_in_cold(d3_cold), .valve_in_hot(d3_hot),
      .valve_out(d3_vout), .motor(d3_motor), .soap_in(d3_soap_in), .soap_warning(d3_warn),
      .lock_door(d3_lock), .paused(d3_paused), .program_done(d3_done), .fault(d3_fault),
      .rem_time(d3_rem)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   exp_t  sbq[$];
   int    done_q[$];
   int    total = 0;
   int    bad = 0;
   string scn;
   int    b, ec, er;
   logic  ef;

   task automatic push_exp(input int which, input int c, input logic [10:0] bits, input int rem);
      exp_t e;
      int   i;
      e.cyc = c;
      e.which = which;
      e.bits = bits;
      e.rem = rem;
      e.name = scn;
      i = 0;
      while (i < sbq.size() && sbq[i].cyc <= c) i++;
      sbq.insert(i, e);
   endtask

   // Phase of len cycles with rem_time counting down.
   task automatic push_ph(input logic [10:0] pat, input int len);
      for (int i = 0; i < len; i++) begin
         push_exp(0, ec, pat | {10'b0, ef}, er);
         ec++;
         er--;
      end
   endtask

   // Frozen cycles: rem_time held.
   task automatic push_hold(input logic [10:0] pat, input int n, input int rem);
      for (int i = 0; i < n; i++) begin
         push_exp(0, ec, pat | {10'b0, ef}, rem);
         ec++;
      end
   endtask

   task automatic push_rinses(input int n);
      for (int i = 0; i < n; i++) begin
         push_ph(PatRinse, 3);
         push_ph(PatDrain, 2);
      end
   endtask

   task automatic push_end();
      push_exp(0, ec, PatDone, 0);
      done_q.push_back(ec);
      push_exp(0, ec + 1, PatIdle, 0);
      ec += 2;
   endtask

   task automatic push_tail();
      push_ph(PatDrain, 2);
      push_rinses(2);
      push_ph(PatSpin, 4);
      push_end();
   endtask

   task automatic push_prog(input logic [10:0] fill_pat);
      push_ph(fill_pat, 2);
      push_ph(PatWash, 3);
      push_tail();
   endtask

   task automatic goto(input int c);
      while (cyc < c) @(negedge clk);
   endtask

   task automatic begin_run(input logic [2:0] p);
      program_selection = p;
      start = 1'b1;
      b = cyc + 1;
      ec = b;
      ef = 1'b0;
   endtask

   exp_t        mon_e;
   int          mon_dc;
   logic [10:0] mon_bits;
   int          mon_rem;

   always @(negedge clk) begin
      if (program_done) begin
         total++;
         if (done_q.size() == 0) begin
            bad++;
            $display("FAIL done_pulse: program_done at cycle %0d, required none", cyc);
         end else begin
            mon_dc = done_q.pop_front();
            if (mon_dc != cyc) begin
               bad++;
               $display("FAIL done_pulse: program_done at cycle %0d, required %0d", cyc, mon_dc);
            end
         end
      end
      while (sbq.size() > 0 && sbq[0].cyc <= cyc) begin
         mon_e = sbq.pop_front();
         total++;
         mon_bits = (mon_e.which == 0) ? w0 : w3;
         mon_rem = (mon_e.which == 0) ? int'(rem_time) : int'(d3_rem);
         if (mon_e.cyc != cyc || mon_bits != mon_e.bits || mon_rem != mon_e.rem) begin
            bad++;
            $display("FAIL %s dut%0d cyc=%0d: got bits=%b rem=%0d, required bits=%b rem=%0d",
                     mon_e.name, mon_e.which, mon_e.cyc, mon_bits, mon_rem, mon_e.bits,
                     mon_e.rem);
         end
      end
   end

   initial begin
      rst = 1'b1;
      power = 1'b1;
      start = 1'b0;
      program_selection = 3'b000;
      door_closed = 1'b1;
      soap = 1'b1;
      pause = 1'b0;
      abort = 1'b0;
      ef = 1'b0;

      scn = "reset";
      push_exp(0, 2, PatIdle, 0);
      push_exp(1, 2, PatIdle, 0);
      goto(3);
      rst = 1'b0;

      // Rinse+dry: 2 passes on dut, 3 passes on dut3.
      scn = "rinse_dry";
      begin_run(3'b010);
      er = 14;
      push_rinses(2);
      push_ph(PatSpin, 4);
      push_end();
      push_exp(1, b, PatRinse, 19);
      push_exp(1, b + 19, PatDone, 0);
      goto(b);
      start = 1'b0;
      goto(b + 21);

      // Cold wash; selection change after start must not matter.
      scn = "cold";
      begin_run(3'b000);
      er = 21;
      push_prog(PatFillCold);
      goto(b);
      start = 1'b0;
      program_selection = 3'b001;
      goto(b + 23);

      // Warm wash; the first FILL cycle with soap low also holds the counter.
      scn = "warm_soap";
      begin_run(3'b100);
      soap = 1'b0;
      er = 21;
      push_hold(PatFillWarm, 1, 21);
      push_hold(PatWaitSoap, 5, 21);
      push_prog(PatFillWarm);
      goto(b);
      start = 1'b0;
      goto(b + 5);
      soap = 1'b1;
      goto(b + 29);

      scn = "pause";
      begin_run(3'b000);
      er = 21;
      push_ph(PatFillCold, 2);
      push_ph(PatWash, 1);
      push_hold(PatPaused, 7, 19);
      push_ph(PatWash, 2);
      push_tail();
      goto(b);
      start = 1'b0;
      goto(b + 2);
      pause = 1'b1;
      goto(b + 9);
      pause = 1'b0;
      goto(b + 30);

      scn = "door_fault";
      begin_run(3'b000);
      er = 21;
      push_ph(PatFillCold, 2);
      push_ph(PatWash, 3);
      push_ph(PatDrain, 2);
      push_rinses(2);
      push_ph(PatSpin, 2);
      ef = 1'b1;
      er = 2;
      push_ph(PatDrain, 2);
      push_exp(0, b + 21, PatFault, 0);
      push_exp(0, b + 24, PatFault, 0);
      goto(b);
      start = 1'b0;
      goto(b + 18);
      door_closed = 1'b0;
      goto(b + 20);
      door_closed = 1'b1;
      goto(b + 25);

      // Abort in DRAIN_W; the accepted start also clears the fault.
      scn = "abort";
      begin_run(3'b000);
      er = 21;
      push_ph(PatFillCold, 2);
      push_ph(PatWash, 3);
      push_ph(PatDrain, 1);
      er = 2;
      push_ph(PatDrain, 2);
      push_exp(0, b + 8, PatIdle, 0);
      goto(b);
      start = 1'b0;
      goto(b + 5);
      abort = 1'b1;
      goto(b + 7);
      abort = 1'b0;
      goto(b + 10);

      scn = "reset_mid";
      begin_run(3'b000);
      er = 21;
      push_ph(PatFillCold, 2);
      push_ph(PatWash, 3);
      push_ph(PatDrain, 2);
      push_ph(PatRinse, 3);
      push_exp(0, b + 10, PatIdle, 0);
      push_exp(0, b + 11, PatIdle, 0);
      goto(b);
      start = 1'b0;
      goto(b + 9);
      @(posedge clk);
      #2 rst = 1'b1;
      @(negedge clk);
      goto(b + 11);
      rst = 1'b0;
      scn = "after_reset";
      begin_run(3'b000);
      er = 21;
      push_prog(PatFillCold);
      goto(b);
      start = 1'b0;
      goto(b + 23);

      scn = "no_start";
      power = 1'b0;
      program_selection = 3'b000;
      start = 1'b1;
      b = cyc;
      push_exp(0, b + 1, PatIdle, 0);
      push_exp(0, b + 2, PatIdle, 0);
      goto(b + 2);
      power = 1'b1;
      program_selection = 3'b101;
      push_exp(0, b + 3, PatIdle, 0);
      push_exp(0, b + 4, PatIdle, 0);
      goto(b + 4);

      scn = "only_dry";
      begin_run(3'b011);
      er = 4;
      push_ph(PatSpin, 4);
      push_end();
      goto(b);
      start = 1'b0;
      goto(b + 8);

      while (sbq.size() > 0) begin
         mon_e = sbq.pop_front();
         total++;
         bad++;
         $display("FAIL %s dut%0d cyc=%0d: got no check, required bits=%b rem=%0d",
                  mon_e.name, mon_e.which, mon_e.cyc, mon_e.bits, mon_e.rem);
      end
      while (done_q.size() > 0) begin
         mon_dc = done_q.pop_front();
         total++;
         bad++;
         $display("FAIL done_pulse: got none, required at cycle %0d", mon_dc);
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
